mpu_imul_sequencer: RTL
=======================

Name: mpu_imul_sequencer

Overview:
Multi-cycle controller for the MPU matrix-by-scalar multiply (5x5 signed 8-bit matrix times signed 8-bit factor). It accepts one command via a valid/ready handshake and latches the operands. It processes LANES elements per cycle through shared multiplier lanes, then holds the 5x5 result until the consumer accepts it. It sits between the MPU instruction decoder (command side) and the MPU result/writeback stage.

Parameters:
LANES, 5, elements multiplied per RUN cycle; legal range 1..25; lanes past element 24 are masked.
SATURATE, 0, 0 = wrap products to 8 bits (two's complement truncation); 1 = clamp to [-128, 127].

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  sequencer can accept a command.
matrix_a  in  200  5x5 signed 8-bit operand; element e = row + 5*col at bits [8*e +: 8].
factor  in  8  signed scalar.
abort  in  1  synchronous cancel of the in-flight command.
busy  out  1  high in RUN or DONE.
result_valid  out  1  result present.
result_ready  in  1  consumer accepts the result.
result  out  200  5x5 signed 8-bit product, same element layout as matrix_a.
overflow  out  1  at least one element product fell outside [-128, 127]; valid with result_valid.

Behaviour:
- Reset (async, immediate): state=IDLE; cmd_ready=1; busy=0; result_valid=0; result=0; overflow=0; element index idx=0.
- States: IDLE, RUN, DONE. cmd_ready = (state==IDLE). busy = (state!=IDLE). result_valid = (state==DONE). All outputs are registered or decoded directly from state; no combinational in-to-out paths.
- IDLE: on an edge with cmd_valid&&cmd_ready:
  - latch matrix_a and factor;
  - idx=0; overflow=0; go to RUN.
  - The result register is not cleared; it is overwritten element by element.
- RUN, each edge:
  - for lane k in 0..LANES-1 with e=idx+k<25: result[8*e +: 8] = wrap or clamp of the 16-bit signed product factor*a[e];
  - overflow |= (product < -128 or > 127);
  - idx += LANES;
  - if idx+LANES >= 25 (the last batch), go to DONE.
- Latency: result_valid rises exactly N=ceil(25/LANES) edges after the accept edge. LANES=5 gives 5; LANES=1 gives 25; LANES=7 gives 4.
- Products are computed at full 16-bit signed width before wrap or clamp. -128 * -128 = 16384, which wraps to 0 or clamps to 127; overflow is set in both modes.
- DONE:
  - result and overflow are held stable while result_valid=1 and result_ready=0;
  - on an edge with result_ready=1, go to IDLE (cmd_ready=1 the next cycle);
  - no back-to-back accept in the same edge.
- cmd_valid is ignored in RUN and DONE; operands are not re-latched.
- abort in RUN or DONE: go to IDLE next edge, result_valid drops, overflow cleared, result contents undefined to the consumer. abort in IDLE has no effect. abort has priority over result_ready and the RUN progression.
- Async reset mid-RUN/DONE discards the command; no partial result is signalled.

Decomposition:
- Shared package mpu_pkg:
  - MPU_DIM=5, MPU_ELEMS=25, MPU_ELEM_W=8, MPU_MATRIX_W=200;
  - element offset function at(col,row)=8*(row+5*col);
  - state encoding constants for IDLE/RUN/DONE.
- Sub-module mpu_imul_lane: one signed 8x8 multiply with a 16-bit product, wrap/clamp selected by SATURATE, and a per-lane overflow output. The sequencer instantiates LANES copies and muxes operands by idx.

Test Plan:
1. LANES=5, matrix_a = 1..25 (element 0 = 1), factor=2 -> result elements 2..50, overflow=0; result_valid exactly 5 edges after accept; cmd_ready returns to 1 one cycle after result_ready handshake.
2. SATURATE=0, matrix_a all 25, factor=10 -> every element = -6 (250 wrapped), overflow=1. SATURATE=1, same stimulus -> all elements 127, overflow=1.
3. Element 0 = -128, rest 0, factor=-1 -> element 0 = -128 with SATURATE=0, 127 with SATURATE=1; overflow=1; all other elements 0.
4. Backpressure: result_ready held low 3 cycles after result_valid, with cmd_valid pulsed meanwhile -> result, overflow and result_valid stable; cmd_ready=0; the second command is not accepted until after the handshake.
5. LANES=1 -> result_valid after 25 edges; LANES=7 -> 4 edges, tail lanes in the last batch masked (elements 25..27 are never written, no X on result).
6. reset asserted asynchronously 2 cycles into RUN -> result_valid=0, result=0, cmd_ready=1 without a clock edge. Separately, abort in RUN cycle 3 -> IDLE next edge, result_valid never asserted, a new command is then processed correctly.

Source files
------------

// File: rtl/mpu_pkg.sv
// mpu_pkg: shared MPU matrix geometry, sequencer state encoding and element addressing.
package mpu_pkg;
    localparam int MPU_DIM      = 5;
    localparam int MPU_ELEMS    = 25;
    localparam int MPU_ELEM_W   = 8;
    localparam int MPU_MATRIX_W = 200;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int at(input int col, input int row);
        return MPU_ELEM_W * (row + MPU_DIM * col);
    endfunction
endpackage

// File: rtl/mpu_imul_lane.sv
// mpu_imul_lane: one signed 8x8 multiply, full 16-bit product, wrap or clamp to 8 bits.
module mpu_imul_lane
    import mpu_pkg::*;
#(
    parameter bit SATURATE = 1'b0
) (
    input  logic [MPU_ELEM_W-1:0] i_a,
    input  logic [MPU_ELEM_W-1:0] i_factor,
    output logic [MPU_ELEM_W-1:0] o_prod,
    output logic                  o_ovf
);
    logic signed [15:0] w_p;

    assign w_p    = $signed(i_a) * $signed(i_factor);
    assign o_ovf  = (w_p > 16'sd127) || (w_p < -16'sd128);
    assign o_prod = (SATURATE && o_ovf) ? (w_p[15] ? 8'h80 : 8'h7f) : w_p[7:0];
endmodule

// File: rtl/mpu_imul_sequencer.sv
// mpu_imul_sequencer: multi-cycle 5x5 matrix-by-scalar multiply, LANES elements per cycle,
// result held until the consumer accepts it.
module mpu_imul_sequencer
    import mpu_pkg::*;
#(
    parameter int LANES    = 5,
    parameter bit SATURATE = 1'b0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [MPU_MATRIX_W-1:0] matrix_a,
    input  logic [MPU_ELEM_W-1:0]   factor,
    input  logic                    abort,
    output logic                    busy,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic [MPU_MATRIX_W-1:0] result,
    output logic                    overflow
);
    state_t                  r_state;
    logic [MPU_MATRIX_W-1:0] r_a;
    logic [MPU_MATRIX_W-1:0] r_result;
    logic [MPU_ELEM_W-1:0]   r_factor;
    logic [5:0]              r_idx;
    logic                    r_ovf;

    logic [LANES-1:0]      w_en;
    logic [LANES-1:0]      w_ovf;
    logic [5:0]            w_sel  [LANES];
    logic [MPU_ELEM_W-1:0] w_prod [LANES];

    // Lanes past element 24 are steered to element 0 and masked by w_en.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [5:0] w_e;
        assign w_e      = r_idx + 6'(k);
        assign w_en[k]  = w_e < 6'(MPU_ELEMS);
        assign w_sel[k] = w_en[k] ? w_e : 6'd0;
        mpu_imul_lane #(.SATURATE(SATURATE)) u_lane (
            .i_a      (r_a[{w_sel[k], 3'b000} +: MPU_ELEM_W]),
            .i_factor (r_factor),
            .o_prod   (w_prod[k]),
            .o_ovf    (w_ovf[k])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_result <= '0;
            r_factor <= '0;
            r_idx    <= '0;
            r_ovf    <= 1'b0;
        end else if (abort && r_state != ST_IDLE) begin
            r_state <= ST_IDLE;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (cmd_valid) begin
                    r_a      <= matrix_a;
                    r_factor <= factor;
                    r_idx    <= '0;
                    r_ovf    <= 1'b0;
                    r_state  <= ST_RUN;
                end
                ST_RUN: begin
                    for (int i = 0; i < LANES; i++)
                        if (w_en[i]) r_result[{w_sel[i], 3'b000} +: MPU_ELEM_W] <= w_prod[i];
                    r_ovf <= r_ovf | (|(w_ovf & w_en));
                    r_idx <= r_idx + 6'(LANES);
                    if (int'(r_idx) + LANES >= MPU_ELEMS) r_state <= ST_DONE;
                end
                ST_DONE: if (result_ready) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready    = r_state == ST_IDLE;
    assign busy         = r_state != ST_IDLE;
    assign result_valid = r_state == ST_DONE;
    assign result       = r_result;
    assign overflow     = r_ovf;
endmodule
